// File: rtl/img28_pkg.sv
// -----------------------------------------------------------------------------
// img28_pkg
// Shared constants for the 28x28 image path on the right display panel.
// Used by img28_buf_ctrl (frame buffer / lookup) and right_panel_gen (drawing).
//   IMG_X_START / IMG_Y_START : top-left corner of the 280x280 image window
//   SCALE                     : display pixels per grid cell, per axis
//   GRID                      : grid cells per axis (frame = GRID*GRID pixels)
//   RGB565_*                  : panel colours
//   wr_state_e                : frame writer states
//   div10                     : cheap floor(v/10) for the cell lookup
// -----------------------------------------------------------------------------
package img28_pkg;

    localparam int IMG_X_START = 116;
    localparam int IMG_Y_START = 244;
    localparam int SCALE       = 10;
    localparam int GRID        = 28;
    localparam int NPIX        = GRID * GRID;
    localparam int WIN         = SCALE * GRID;

    localparam logic [15:0] RGB565_BLACK  = 16'h0000;
    localparam logic [15:0] RGB565_WHITE  = 16'hFFFF;
    localparam logic [15:0] RGB565_BORDER = 16'h07E0;
    localparam logic [15:0] RGB565_BG     = 16'h18E3;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_FILL = 2'd1,
        WR_FULL = 2'd2
    } wr_state_e;

    // floor(v/10) as (v*205)>>11; exact for v < 1029, which covers the
    // 0..279 window offsets. Out-of-window results are masked by the caller.
    function automatic logic [4:0] div10(input logic [10:0] v);
        logic [18:0] p;
        p = 19'(v) * 19'd205;
        return 5'(p >> 11);
    endfunction

endpackage

// File: rtl/img28_bank_ram.sv
// -----------------------------------------------------------------------------
// img28_bank_ram
// Two banks of DEPTH x 1-bit pixel storage (ping-pong frame buffer).
// Contents are deliberately not reset.
//   clk                         : clock
//   we, wr_bank, wr_addr, wr_data : single write port
//   rd_bank, rd_addr            : read address (sampled on clk)
//   rd_data                     : registered read data, one cycle later
// -----------------------------------------------------------------------------
module img28_bank_ram
    import img28_pkg::*;
#(
    parameter int DEPTH = img28_pkg::NPIX
) (
    input  logic       clk,
    input  logic       we,
    input  logic       wr_bank,
    input  logic [9:0] wr_addr,
    input  logic       wr_data,
    input  logic       rd_bank,
    input  logic [9:0] rd_addr,
    output logic       rd_data
);

    logic mem [0:1][0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_bank][rd_addr];
    end

endmodule

// File: rtl/img28_buf_ctrl.sv
// -----------------------------------------------------------------------------
// img28_buf_ctrl
// Ping-pong frame buffer between pixel_scaler (28x28 binary frames, raster
// order) and the right-panel scan. The writer fills the back bank; a full back
// bank is promoted to front on the next display frame_start.
//   pixel_clk, rst_n              : clock, async active-low reset
//   wr_sof, wr_pixel, wr_valid    : incoming frame pixels (sof marks index 0)
//   frame_start                   : display vsync pulse
//   pixel_x, pixel_y, pixel_valid : scan coordinates
//   binary_pixel, binary_valid    : looked-up pixel, one cycle later
//   pixel_x_d, pixel_y_d, pixel_valid_d : scan inputs aligned with binary_*
//   fill_busy                     : writer is filling a frame
//   front_sel                     : bank currently displayed
//   drop_cnt                      : saturating count of dropped frames
// -----------------------------------------------------------------------------
module img28_buf_ctrl
    import img28_pkg::*;
#(
    parameter int IMG_X_START = img28_pkg::IMG_X_START,
    parameter int IMG_Y_START = img28_pkg::IMG_Y_START,
    parameter int SCALE       = img28_pkg::SCALE,
    parameter int GRID        = img28_pkg::GRID
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic        wr_sof,
    input  logic        wr_pixel,
    input  logic        wr_valid,
    input  logic        frame_start,
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    input  logic        pixel_valid,
    output logic        binary_pixel,
    output logic        binary_valid,
    output logic [10:0] pixel_x_d,
    output logic [10:0] pixel_y_d,
    output logic        pixel_valid_d,
    output logic        fill_busy,
    output logic        front_sel,
    output logic [7:0]  drop_cnt
);

    localparam int         NPIX_P   = GRID * GRID;
    localparam int         WIN_P    = SCALE * GRID;
    localparam logic [9:0] LAST_IDX = 10'(NPIX_P - 1);

    wr_state_e   state_q, state_d;
    logic [9:0]  wr_idx_q, wr_idx_d;
    logic        front_sel_q, front_sel_d;
    logic        disp_valid_q, disp_valid_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    logic        sof;
    logic        ram_we;
    logic [9:0]  ram_waddr;
    logic        ram_wbank;

    // ---------------- writer ----------------
    always_comb begin
        state_d      = state_q;
        wr_idx_d     = wr_idx_q;
        front_sel_d  = front_sel_q;
        disp_valid_d = disp_valid_q;
        drop_cnt_d   = drop_cnt_q;
        ram_we       = 1'b0;
        ram_waddr    = wr_idx_q;
        sof          = wr_valid & wr_sof;

        case (state_q)
            WR_IDLE: begin
                if (sof) begin
                    ram_we    = 1'b1;
                    ram_waddr = 10'd0;
                    wr_idx_d  = 10'd1;
                    state_d   = WR_FILL;
                end
            end
            WR_FILL: begin
                // A new sof aborts the partial frame; it is not a drop.
                // frame_start is ignored here, even on the final write.
                if (sof) begin
                    ram_we    = 1'b1;
                    ram_waddr = 10'd0;
                    wr_idx_d  = 10'd1;
                end else if (wr_valid) begin
                    ram_we = 1'b1;
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d = 10'd0;
                        state_d  = WR_FULL;
                    end else begin
                        wr_idx_d = wr_idx_q + 10'd1;
                    end
                end
            end
            WR_FULL: begin
                if (frame_start) begin
                    front_sel_d  = ~front_sel_q;
                    disp_valid_d = 1'b1;
                    // sof in the swap cycle lands in the freshly freed bank.
                    if (sof) begin
                        ram_we    = 1'b1;
                        ram_waddr = 10'd0;
                        wr_idx_d  = 10'd1;
                        state_d   = WR_FILL;
                    end else begin
                        state_d = WR_IDLE;
                    end
                end else if (sof && (drop_cnt_q != 8'hFF)) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = WR_IDLE;
            end
        endcase
    end

    // Back bank follows the post-swap front so a same-cycle sof hits the new back.
    assign ram_wbank = ~front_sel_d;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WR_IDLE;
            wr_idx_q     <= 10'd0;
            front_sel_q  <= 1'b0;
            disp_valid_q <= 1'b0;
            drop_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            wr_idx_q     <= wr_idx_d;
            front_sel_q  <= front_sel_d;
            disp_valid_q <= disp_valid_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // ---------------- reader ----------------
    logic signed [11:0] dx, dy;
    logic               in_win;
    logic [4:0]         col, row;
    logic [9:0]         rd_addr;
    logic               binary_valid_d;
    logic               binary_valid_q;
    logic [10:0]        pixel_x_q, pixel_y_q;
    logic               pixel_valid_q;
    logic               ram_rd_data;

    always_comb begin
        dx     = $signed({1'b0, pixel_x}) - $signed(12'(IMG_X_START));
        dy     = $signed({1'b0, pixel_y}) - $signed(12'(IMG_Y_START));
        in_win = (dx >= 12'sd0) && (dx < $signed(12'(WIN_P))) &&
                 (dy >= 12'sd0) && (dy < $signed(12'(WIN_P)));
        col    = div10(dx[10:0]);
        row    = div10(dy[10:0]);
        rd_addr        = 10'(row) * 10'(GRID) + 10'(col);
        binary_valid_d = pixel_valid & in_win & disp_valid_q;
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            binary_valid_q <= 1'b0;
            pixel_x_q      <= 11'd0;
            pixel_y_q      <= 11'd0;
            pixel_valid_q  <= 1'b0;
        end else begin
            binary_valid_q <= binary_valid_d;
            pixel_x_q      <= pixel_x;
            pixel_y_q      <= pixel_y;
            pixel_valid_q  <= pixel_valid;
        end
    end

    img28_bank_ram #(
        .DEPTH (NPIX_P)
    ) u_ram (
        .clk     (pixel_clk),
        .we      (ram_we),
        .wr_bank (ram_wbank),
        .wr_addr (ram_waddr),
        .wr_data (wr_pixel),
        .rd_bank (front_sel_q),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    // RAM output is unreset; gating by the valid flop keeps it 0 out of window,
    // before the first swap and after reset.
    assign binary_pixel  = ram_rd_data & binary_valid_q;
    assign binary_valid  = binary_valid_q;
    assign pixel_x_d     = pixel_x_q;
    assign pixel_y_d     = pixel_y_q;
    assign pixel_valid_d = pixel_valid_q;
    assign fill_busy     = (state_q == WR_FILL);
    assign front_sel     = front_sel_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_img28_buf_ctrl.sv
module tb_img28_buf_ctrl;

    logic        pixel_clk;
    logic        rst_n;
    logic        wr_sof, wr_pixel, wr_valid, frame_start;
    logic [10:0] pixel_x, pixel_y;
    logic        pixel_valid;
    logic        binary_pixel, binary_valid;
    logic [10:0] pixel_x_d, pixel_y_d;
    logic        pixel_valid_d, fill_busy, front_sel;
    logic [7:0]  drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    img28_buf_ctrl dut (
        .pixel_clk     (pixel_clk),
        .rst_n         (rst_n),
        .wr_sof        (wr_sof),
        .wr_pixel      (wr_pixel),
        .wr_valid      (wr_valid),
        .frame_start   (frame_start),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .pixel_valid   (pixel_valid),
        .binary_pixel  (binary_pixel),
        .binary_valid  (binary_valid),
        .pixel_x_d     (pixel_x_d),
        .pixel_y_d     (pixel_y_d),
        .pixel_valid_d (pixel_valid_d),
        .fill_busy     (fill_busy),
        .front_sel     (front_sel),
        .drop_cnt      (drop_cnt)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Frame patterns, indexed by raster position (row*28+col).
    function automatic bit pat_pix(input int pat, input int idx);
        case (pat)
            0:       return bit'(((idx / 28) + (idx % 28)) & 1);
            1:       return (idx % 3) == 0;
            2:       return 1'b1;
            3:       return (idx % 7) == 0;
            4:       return (idx % 5) == 0;
            5:       return bit'(idx % 2);
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic write_frame(input int pat, input int n, input bit fs_last);
        for (int i = 0; i < n; i++) begin
            wr_valid    = 1'b1;
            wr_sof      = (i == 0);
            wr_pixel    = pat_pix(pat, i);
            frame_start = fs_last && (i == n - 1);
            tick();
        end
        wr_valid = 1'b0; wr_sof = 1'b0; wr_pixel = 1'b0; frame_start = 1'b0;
    endtask

    task automatic write_cont(input int pat, input int from, input int upto);
        for (int i = from; i <= upto; i++) begin
            wr_valid = 1'b1;
            wr_sof   = 1'b0;
            wr_pixel = pat_pix(pat, i);
            tick();
        end
        wr_valid = 1'b0; wr_pixel = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pulse_sof();
        wr_valid = 1'b1;
        wr_sof   = 1'b1;
        tick();
        wr_valid = 1'b0;
        wr_sof   = 1'b0;
    endtask

    task automatic probe(input string tag, input int x, input int y, input bit pv,
                         input bit ev, input bit ep);
        pixel_x     = 11'(x);
        pixel_y     = 11'(y);
        pixel_valid = pv;
        tick();
        chk({tag, ".valid"}, 32'(binary_valid), 32'(ev));
        chk({tag, ".pix"},   32'(binary_pixel), 32'(ep));
        pixel_valid = 1'b0;
    endtask

    // Probe inside a cell at a non-zero offset to exercise the /10 lookup.
    task automatic probe_cell(input string tag, input int idx, input bit ep);
        probe(tag, 116 + 10 * (idx % 28) + 9, 244 + 10 * (idx / 28) + 5, 1'b1, 1'b1, ep);
    endtask

    initial begin
        bit any_valid;
        rst_n = 1'b0;
        wr_sof = 1'b0; wr_pixel = 1'b0; wr_valid = 1'b0; frame_start = 1'b0;
        pixel_x = 11'd0; pixel_y = 11'd0; pixel_valid = 1'b0;
        tick();
        tick();
        chk("rst.binary_valid",  32'(binary_valid), 0);
        chk("rst.binary_pixel",  32'(binary_pixel), 0);
        chk("rst.pixel_valid_d", 32'(pixel_valid_d), 0);
        chk("rst.pixel_x_d",     32'(pixel_x_d), 0);
        chk("rst.fill_busy",     32'(fill_busy), 0);
        chk("rst.front_sel",     32'(front_sel), 0);
        chk("rst.drop_cnt",      32'(drop_cnt), 0);
        rst_n = 1'b1;
        tick();

        // No frame displayed yet: every cell of the window must stay invalid.
        any_valid = 1'b0;
        for (int y = 244; y < 524; y += 10) begin
            for (int x = 116; x < 396; x += 10) begin
                pixel_x = 11'(x); pixel_y = 11'(y); pixel_valid = 1'b1;
                tick();
                if (binary_valid) any_valid = 1'b1;
            end
        end
        pixel_valid = 1'b0;
        tick();
        chk("scan_before_disp", 32'(any_valid), 0);

        // Checkerboard frame, then swap.
        write_frame(0, 784, 1'b0);
        chk("cb.full_not_busy", 32'(fill_busy), 0);
        chk("cb.front_before",  32'(front_sel), 0);
        pulse_fs();
        chk("cb.front_after", 32'(front_sel), 1);
        probe("cb.116_244", 116, 244, 1'b1, 1'b1, 1'b0);
        chk("cb.pixel_x_d",     32'(pixel_x_d), 116);
        chk("cb.pixel_y_d",     32'(pixel_y_d), 244);
        chk("cb.pixel_valid_d", 32'(pixel_valid_d), 1);
        probe("cb.126_244", 126, 244, 1'b1, 1'b1, 1'b1);
        probe("cb.395_523", 395, 523, 1'b1, 1'b1, 1'b0);
        probe("cb.395_244", 395, 244, 1'b1, 1'b1, 1'b1);
        probe("cb.136_254", 136, 254, 1'b1, 1'b1, 1'b1);
        probe("cb.pv0",     126, 244, 1'b0, 1'b0, 1'b0);
        chk("cb.pixel_valid_d0", 32'(pixel_valid_d), 0);
        probe("edge.x115", 115, 300, 1'b1, 1'b0, 1'b0);
        probe("edge.x116", 116, 300, 1'b1, 1'b1, 1'b1);
        probe("edge.x395", 395, 300, 1'b1, 1'b1, 1'b0);
        probe("edge.x396", 396, 300, 1'b1, 1'b0, 1'b0);
        probe("edge.y243", 200, 243, 1'b1, 1'b0, 1'b0);
        probe("edge.y524", 200, 524, 1'b1, 1'b0, 1'b0);

        // frame_start while IDLE does nothing.
        pulse_fs();
        chk("idle_fs.front", 32'(front_sel), 1);

        // 2nd frame fills, 3rd is dropped, then saturate.
        write_frame(1, 784, 1'b0);
        chk("drop.full",   32'(fill_busy), 0);
        chk("drop.zero",   32'(drop_cnt), 0);
        write_frame(2, 20, 1'b0);
        chk("drop.one",    32'(drop_cnt), 1);
        chk("drop.front",  32'(front_sel), 1);
        for (int i = 0; i < 253; i++) pulse_sof();
        chk("drop.254", 32'(drop_cnt), 254);
        pulse_sof();
        chk("drop.255", 32'(drop_cnt), 255);
        pulse_sof();
        chk("drop.sat", 32'(drop_cnt), 255);
        pulse_fs();
        chk("drop.swap", 32'(front_sel), 0);
        probe_cell("p1.c0",   0,   1'b1);
        probe_cell("p1.c1",   1,   1'b0);
        probe_cell("p1.c3",   3,   1'b1);
        probe_cell("p1.c783", 783, 1'b1);

        // Restart mid-fill at index 500: only the new frame is visible.
        write_frame(2, 500, 1'b0);
        chk("restart.busy", 32'(fill_busy), 1);
        pulse_fs();
        chk("fill_fs.front", 32'(front_sel), 0);
        write_frame(3, 784, 1'b0);
        chk("restart.full", 32'(fill_busy), 0);
        chk("restart.drop", 32'(drop_cnt), 255);
        pulse_fs();
        chk("restart.swap", 32'(front_sel), 1);
        probe_cell("p3.c0",   0,   1'b1);
        probe_cell("p3.c1",   1,   1'b0);
        probe_cell("p3.c7",   7,   1'b1);
        probe_cell("p3.c499", 499, 1'b0);
        probe_cell("p3.c500", 500, 1'b0);
        probe_cell("p3.c782", 782, 1'b0);

        // Last write coinciding with frame_start: no swap until the next one.
        write_frame(4, 784, 1'b1);
        chk("lastfs.front", 32'(front_sel), 1);
        chk("lastfs.full",  32'(fill_busy), 0);
        probe_cell("lastfs.old_c7", 7, 1'b1);
        pulse_fs();
        chk("lastfs.swap", 32'(front_sel), 0);
        probe_cell("p4.c0", 0, 1'b1);
        probe_cell("p4.c5", 5, 1'b1);
        probe_cell("p4.c7", 7, 1'b0);

        // Reset in the middle of a fill.
        write_frame(0, 300, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("mrst.busy",  32'(fill_busy), 0);
        chk("mrst.front", 32'(front_sel), 0);
        chk("mrst.drop",  32'(drop_cnt), 0);
        tick();
        rst_n = 1'b1;
        tick();
        probe("mrst.masked", 116 + 10 * 5 + 9, 249, 1'b1, 1'b0, 1'b0);

        // Swap and sof in the same cycle: new frame goes into the freed bank.
        write_frame(2, 784, 1'b0);
        chk("sim.full", 32'(fill_busy), 0);
        wr_valid = 1'b1; wr_sof = 1'b1; wr_pixel = pat_pix(5, 0); frame_start = 1'b1;
        tick();
        wr_valid = 1'b0; wr_sof = 1'b0; wr_pixel = 1'b0; frame_start = 1'b0;
        chk("sim.front", 32'(front_sel), 1);
        chk("sim.busy",  32'(fill_busy), 1);
        chk("sim.drop",  32'(drop_cnt), 0);
        write_cont(5, 1, 783);
        chk("sim.full2", 32'(fill_busy), 0);
        pulse_fs();
        chk("sim.swap", 32'(front_sel), 0);
        probe_cell("p5.c0", 0, 1'b0);
        probe_cell("p5.c1", 1, 1'b1);
        probe_cell("p5.c3", 3, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
